// File: rtl/wb_l2_arbiter_pkg.sv
// Shared types for the core-to-L2 wishbone arbiter: grant states and line/mask types.
package wb_l2_arbiter_pkg;

  localparam int LINE_W = 128;
  localparam int MASK_W = LINE_W / 8;

  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [MASK_W-1:0] lc3b_mask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_M = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_l2_arbiter_stall_ctr.sv
// Saturating stall counter with synchronous clear; only built when ARB_STATS_EN is defined.
`ifdef ARB_STATS_EN
module wb_arb_stall_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // clear wins over increment so software reads a clean zero next cycle
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule
`endif

// File: rtl/wb_l2_arbiter.sv
// Two-requester classic wishbone arbiter (ifetch, memory) in front of L2.
// Optional stall counters are enabled with the ARB_STATS_EN macro.
module wb_l2_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 128,
  parameter int SEL_W        = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ARB_STATS_EN
  input  logic              ifetch_stall_clear,
  input  logic              memory_stall_clear,
  output logic [15:0]       ifetch_stall,
  output logic [15:0]       memory_stall,
`endif
  input  logic              ifetch_cyc,
  input  logic              ifetch_stb,
  input  logic              ifetch_we,
  input  logic [ADDR_W-1:0] ifetch_adr,
  input  logic [DATA_W-1:0] ifetch_dat_m,
  input  logic [SEL_W-1:0]  ifetch_sel,
  output logic [DATA_W-1:0] ifetch_dat_s,
  output logic              ifetch_ack,
  input  logic              memory_cyc,
  input  logic              memory_stb,
  input  logic              memory_we,
  input  logic [ADDR_W-1:0] memory_adr,
  input  logic [DATA_W-1:0] memory_dat_m,
  input  logic [SEL_W-1:0]  memory_sel,
  output logic [DATA_W-1:0] memory_dat_s,
  output logic              memory_ack,
  output logic              l2_cyc,
  output logic              l2_stb,
  output logic              l2_we,
  output logic [ADDR_W-1:0] l2_adr,
  output logic [DATA_W-1:0] l2_dat_m,
  output logic [SEL_W-1:0]  l2_sel,
  input  logic [DATA_W-1:0] l2_dat_s,
  input  logic              l2_ack
);
  import wb_l2_arbiter_pkg::*;

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  arb_state_t        state, state_nxt;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;
  logic              req_i, req_m;
  logic [DATA_W-1:0] ifetch_dat_hold, memory_dat_hold;

  function automatic logic [SC_W-1:0] starve_sat_inc(input logic [SC_W-1:0] v);
    return (v == STARVE_MAX) ? v : v + SC_W'(1);
  endfunction

  assign req_i = ifetch_cyc & ifetch_stb;
  assign req_m = memory_cyc & memory_stb;

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (req_m && !(req_i && starve_cnt == STARVE_MAX)) begin
          state_nxt = GRANT_M;
          if (req_i) starve_nxt = starve_sat_inc(starve_cnt);
        end else if (req_i) begin
          state_nxt  = GRANT_I;
          starve_nxt = '0;
        end
      end
      // ACK or an abort (CYC dropped) both end the grant via an IDLE bubble
      GRANT_I: if (!ifetch_cyc || l2_ack) state_nxt = IDLE;
      GRANT_M: if (!memory_cyc || l2_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // the ungranted port keeps presenting the last line it was given
  always_ff @(posedge clk) begin
    if (state == GRANT_I) ifetch_dat_hold <= l2_dat_s;
    if (state == GRANT_M) memory_dat_hold <= l2_dat_s;
  end

  always_comb begin
    l2_cyc       = 1'b0;
    l2_stb       = 1'b0;
    l2_we        = 1'b0;
    l2_adr       = '0;
    l2_dat_m     = '0;
    l2_sel       = '0;
    ifetch_ack   = 1'b0;
    memory_ack   = 1'b0;
    ifetch_dat_s = ifetch_dat_hold;
    memory_dat_s = memory_dat_hold;
    case (state)
      GRANT_I: begin
        l2_cyc       = ifetch_cyc;
        l2_stb       = ifetch_stb;
        l2_we        = ifetch_we;
        l2_adr       = ifetch_adr;
        l2_dat_m     = ifetch_dat_m;
        l2_sel       = ifetch_sel;
        ifetch_ack   = l2_ack & ifetch_cyc;
        ifetch_dat_s = l2_dat_s;
      end
      GRANT_M: begin
        l2_cyc       = memory_cyc;
        l2_stb       = memory_stb;
        l2_we        = memory_we;
        l2_adr       = memory_adr;
        l2_dat_m     = memory_dat_m;
        l2_sel       = memory_sel;
        memory_ack   = l2_ack & memory_cyc;
        memory_dat_s = l2_dat_s;
      end
      default: ;
    endcase
  end

`ifdef ARB_STATS_EN
  wb_arb_stall_ctr #(.CNT_W(16)) u_ifetch_stall (
    .clk   (clk),
    .rst   (rst),
    .clr   (ifetch_stall_clear),
    .inc   (req_i & ~ifetch_ack),
    .count (ifetch_stall)
  );

  wb_arb_stall_ctr #(.CNT_W(16)) u_memory_stall (
    .clk   (clk),
    .rst   (rst),
    .clr   (memory_stall_clear),
    .inc   (req_m & ~memory_ack),
    .count (memory_stall)
  );
`endif

endmodule

// File: doc/wb_l2_arbiter.md
Name: wb_l2_arbiter

Overview:
- Wishbone responder for both core-side masters (ifetch, memory).
- Accepts one 128-bit line request at a time and forwards it over a single wishbone master port to the L2 cache.
- Routes the L2 response back to the granted requester only.
- Sits between the core's two wishbone master ports and L2; classic (non-pipelined) wishbone: STB held until ACK.

Parameters:
- ADDR_W, 12, ADR width (128-bit line address).
- DATA_W, 128, DAT_M/DAT_S width.
- SEL_W, 16, byte-select width (DATA_W/8).
- STARVE_LIMIT, 4, consecutive memory grants with ifetch waiting before ifetch is forced to win.

Ports:
- clk  input  1  clock; same clock as the wishbone CLK.
- rst  input  1  synchronous active-high reset.
- ifetch  wishbone.slave  -  instruction-side requester (CYC, STB, WE, ADR, DAT_M, SEL in; DAT_S, ACK out).
- memory  wishbone.slave  -  data-side requester, same signal set.
- l2  wishbone.master  -  downstream to L2 (CYC, STB, WE, ADR, DAT_M, SEL out; DAT_S, ACK in).

Behaviour:
- States are IDLE, GRANT_I and GRANT_M; the state register is the only grant source.
- Request definition: req_x = x.CYC & x.STB.
- IDLE transitions:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: memory wins, unless starve_cnt == STARVE_LIMIT, in which case ifetch wins.
- Grant takes effect on the next edge, so there is exactly one cycle from request to l2.CYC.
- In GRANT_x:
  - l2.CYC/STB/WE/ADR/DAT_M/SEL are driven combinationally from port x.
  - x.ACK = l2.ACK; x.DAT_S = l2.DAT_S.
  - The other port sees ACK=0, and its DAT_S holds its last value (don't-care).
- Leaving GRANT_x:
  - l2.ACK=1 returns to IDLE on the next edge. This one-cycle bubble lets the requester drop CYC.
  - A back-to-back request from the same port is re-arbitrated.
- Abort: x.CYC=0 in GRANT_x returns to IDLE. l2.CYC drops the same cycle because it is forwarded, and a late l2.ACK is not routed anywhere.
- IDLE outputs: l2.CYC=STB=WE=0, ADR=0, DAT_M=0, SEL=0; both ACK=0.
- Reset:
  - rst=1 forces IDLE and starve_cnt=0; all outputs take their IDLE values the cycle after rst samples high.
  - Reset mid-transaction aborts the transaction with no ACK to either port.
- starve_cnt (width $clog2(STARVE_LIMIT+1)):
  - Increments, saturating at STARVE_LIMIT, on each IDLE→GRANT_M while req_i=1.
  - Clears on every IDLE→GRANT_I.
  - Otherwise holds.
- A single requester never stalls more than the one arbitration cycle.
- ifetch.WE is tied 0 upstream, but the arbiter forwards WE from either port without special-casing.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds outputs ifetch_stall[15:0] and memory_stall[15:0], plus inputs ifetch_stall_clear and memory_stall_clear.
  - Each counter increments on every cycle its port has req=1 and ACK=0, saturating at 16'hFFFF.
  - The clear input zeroes its counter next cycle; clear has priority over increment.
  - rst zeroes both counters.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package (lc3b_types or a new arb package):
  - arb_state_t enum {IDLE, GRANT_I, GRANT_M}.
  - Line-width constants DATA_W and SEL_W as typedef lc3b_line / lc3b_mask, if not already present.
- Sub-module wb_arb_stall_ctr (16-bit saturating counter with clear and increment, instantiated twice) under ARB_STATS_EN.
- Arbiter FSM and muxing stay in wb_l2_arbiter.

Test Plan:
- Single ifetch read:
  - Stimulus: ifetch CYC/STB=1, ADR=12'h040; l2 ACKs after 3 cycles with DAT_S=128'hA5..A5.
  - Required: l2.ADR=12'h040 one cycle after the request; ifetch.ACK=1 and DAT_S=A5..A5 in the ACK cycle; memory.ACK stays 0.
- Simultaneous requests: ifetch ADR=12'h010 and memory ADR=12'h200, both held.
  - Required: memory is granted first (l2.ADR=12'h200).
  - After memory's ACK and a one-cycle bubble, l2.ADR=12'h010.
- Starvation: ifetch held; memory re-requests back-to-back 5 times.
  - Required: grants go M,M,M,M,I (STARVE_LIMIT=4), then starve_cnt=0 and M is next.
- Memory write:
  - Stimulus: memory WE=1, SEL=16'h0003, DAT_M=128'h...BEEF.
  - Required: l2 sees identical WE/SEL/DAT_M; memory.ACK mirrors l2.ACK.
- Abort/reset:
  - Stimulus: memory CYC drops in GRANT_M before ACK, then l2.ACK pulses.
  - Required: l2.CYC=0 the same cycle; no ACK on either port; state returns to IDLE.
  - Repeat with rst=1 mid-grant: same result and starve_cnt=0.
- ARB_STATS_EN:
  - Stimulus: ifetch waits 6 cycles for ACK; memory idle.
  - Required: ifetch_stall=6 and memory_stall=0.
  - ifetch_stall_clear pulse gives ifetch_stall=0 next cycle.
